priority_sort_seq: RTL

Parametrised, sequential successor to the fixed 4-client priority sorter. It snapshots CLIENT_NR client priorities and a request mask on a start handshake, then ranks requesting clients one output slot per cycle: ascending priority value, ties to the lower client index. It reports the ordered address list, per-slot valid bits, valid count and a duplicate-priority flag. It sits in front of the bus arbiter's grant sequencer, which consumes the ordered list after done.

---
 rtl/priority_sort_seq.sv | 87 ++++++++
 1 files changed

// File: rtl/priority_sort_seq.sv
// priority_sort_seq: ranks snapshotted requesting clients by ascending priority, one output slot per cycle
module priority_sort_seq #(
    parameter int CLIENT_NR = 4,
    parameter int PRIO_W = 2,
    localparam int ADDR_W = $clog2(CLIENT_NR)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CLIENT_NR-1:0]          client_req,
    input  logic [CLIENT_NR*PRIO_W-1:0]   client_priority,
    output logic                          busy,
    output logic                          done,
    output logic [CLIENT_NR*ADDR_W-1:0]   sorted_addr,
    output logic [CLIENT_NR-1:0]          sorted_valid,
    output logic [ADDR_W:0]               valid_count,
    output logic                          dup_error
);
    typedef enum logic {IDLE, SORT} state_t;
    state_t state;
    logic [CLIENT_NR-1:0] req_q, placed, cand;
    logic [CLIENT_NR*PRIO_W-1:0] prio_q;
    logic [ADDR_W-1:0] cnt, best_idx;
    logic [PRIO_W-1:0] best_prio;
    logic found, dup;
    // lowest index wins ties because only a strictly smaller value replaces the current best
    always_comb begin
        cand = req_q & ~placed;
        found = 1'b0;
        best_idx = '0;
        best_prio = '0;
        dup = 1'b0;
        for (int i = 0; i < CLIENT_NR; i++)
            if (cand[i] && (!found || prio_q[i*PRIO_W +: PRIO_W] < best_prio)) begin
                found = 1'b1;
                best_idx = ADDR_W'(i);
                best_prio = prio_q[i*PRIO_W +: PRIO_W];
            end
        for (int i = 0; i < CLIENT_NR; i++)
            if (cand[i] && ADDR_W'(i) != best_idx && prio_q[i*PRIO_W +: PRIO_W] == best_prio)
                dup = 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            sorted_addr <= '0;
            sorted_valid <= '0;
            valid_count <= '0;
            dup_error <= 1'b0;
            req_q <= '0;
            prio_q <= '0;
            placed <= '0;
            cnt <= '0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                req_q <= client_req;
                prio_q <= client_priority;
                placed <= '0;
                sorted_addr <= '0;
                sorted_valid <= '0;
                valid_count <= '0;
                dup_error <= 1'b0;
                cnt <= '0;
                busy <= 1'b1;
                state <= SORT;
            end
        end else begin
            if (found) begin
                sorted_addr[cnt*ADDR_W +: ADDR_W] <= best_idx;
                sorted_valid[cnt] <= 1'b1;
                placed[best_idx] <= 1'b1;
                valid_count <= valid_count + (ADDR_W+1)'(1);
            end
            if (dup)
                dup_error <= 1'b1;
            cnt <= cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(CLIENT_NR-1)) begin
                state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule
